inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Writer side of the instruction-memory interface. Owns the 2^ADDR_W-word instruction RAM.
- Fills the RAM from a byte stream (UART/debug bridge) at boot, assembling big-endian 32-bit words.
- Serves the combinational instruction read used by the single-cycle fetch unit.
- Holds the CPU out of run until the load completes.

Parameters:
- ADDR_W, 16, word-address width; RAM depth 2^ADDR_W words (256 KB at default).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  single-cycle pulse; begins a load session.
- load_len  in  ADDR_W+1  number of 32-bit words to load; sampled with load_start.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- fetch_pc  in  32  fetch-unit PC (byte address).
- inst  out  32  instruction word at fetch_pc.
- busy  out  1  load session in progress.
- cpu_run  out  1  load complete; CPU may run. Intended to drive the CPU reset release.
- words_loaded  out  ADDR_W+1  words written in the current or last session.
- checksum  out  32  XOR of all words written in the current or last session.

Behaviour:
- States: IDLE, LOAD, DONE. Every flop updates only on the rising edge of clk.
- Reset (rst=1 at an edge):
  - state=IDLE; byte_ready=0; busy=0; cpu_run=0; words_loaded=0; checksum=0.
  - Byte counter and word assembly register cleared.
  - RAM contents are not cleared.
- IDLE:
  - load_start=1 with load_len!=0 -> LOAD.
  - load_start=1 with load_len==0 -> DONE.
  - On either transition: words_loaded and checksum clear to 0.
  - load_len values above 2^ADDR_W saturate to 2^ADDR_W when latched.
- LOAD:
  - busy=1, cpu_run=0. byte_ready is a registered output equal to 1 throughout LOAD.
  - A byte is accepted when byte_valid & byte_ready.
  - Byte order: accepted bytes 0..3 of a word fill bits [31:24], [23:16], [15:8], [7:0].
  - On the edge accepting byte 3:
    - the assembled word is written to RAM[words_loaded];
    - words_loaded increments;
    - checksum ^= word;
    - the byte counter wraps to 0.
  - When that increment makes words_loaded equal the latched length, the FSM moves to DONE on the same edge. byte_ready is 0 from the next cycle, so no extra byte is accepted.
  - byte_valid gaps (no accepted byte) leave all state unchanged.
  - load_start during LOAD is ignored.
- DONE:
  - busy=0, cpu_run=1, byte_ready=0.
  - load_start=1 re-enters LOAD (or stays in DONE if load_len==0) with the same clearing as from IDLE.
  - cpu_run drops to 0 on that same edge.
- Read port:
  - inst = RAM[fetch_pc[ADDR_W+1:2]], combinational (the single-cycle CPU needs it).
  - fetch_pc[1:0] and bits above ADDR_W+1 are ignored; addresses wrap.
  - While busy=1, inst is forced to 32'h00000000 (MIPS nop).
  - Writes happen only in LOAD, so there is no read/write collision when cpu_run=1.
- Reset mid-load: the session is abandoned and the FSM returns to IDLE.
  - Partially assembled bytes are discarded.
  - Words already written stay in RAM, but cpu_run stays 0 until a new session completes.
- Simultaneous events:
  - rst has priority over load_start and byte acceptance.
  - The word-write and the DONE transition occur on the same edge.

Test Plan:
- Reset, then load_start with load_len=2; stream 8C,01,00,04,00,00,00,08 with continuous valid.
  - RAM[0]=8C010004 and RAM[1]=00000008; checksum=8C01000C; words_loaded=2.
  - cpu_run=1 the cycle after the 8th byte; byte_ready=0 thereafter.
  - fetch_pc=4 -> inst=00000008; fetch_pc=7 -> inst=00000008.
- Same load with byte_valid toggled 1/0 every cycle.
  - Identical RAM and checksum; completion takes 16 cycles.
  - busy=1 throughout, and inst=0 for any fetch_pc while busy.
- load_len=1; after 2 bytes assert rst for one cycle; then start a new session and load 12345678.
  - After the reset: state IDLE, cpu_run=0.
  - Second session: RAM[0]=12345678; partial bytes from the first session have no effect.
- In DONE, pulse load_start with load_len=1 and stream DEADBEEF.
  - cpu_run drops to 0 on the pulse edge.
  - checksum=DEADBEEF (cleared, not accumulated); RAM[1] unchanged.
- load_start with load_len=0 -> DONE the next cycle, cpu_run=1, byte_ready never asserted.
- Pulse load_start again during LOAD -> no effect; the session completes at the original length.

Source files
------------

// File: rtl/inst_loader_if.sv
// ----------------------------------------------------------------------------
// inst_loader_if
//   Bundle of the boot-loader byte stream, load control, status and the
//   fetch read port of the instruction RAM.
//   master : the side that drives the load session and the fetch PC
//            (boot bridge / fetch unit / testbench).
//   slave  : inst_loader itself.
//   ADDR_W must match the ADDR_W of the inst_loader instance it connects to.
// ----------------------------------------------------------------------------
interface inst_loader_if #(
   parameter int ADDR_W = 16
);
   logic              load_start;
   logic [ADDR_W:0]   load_len;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic [31:0]       fetch_pc;
   logic [31:0]       inst;
   logic              busy;
   logic              cpu_run;
   logic [ADDR_W:0]   words_loaded;
   logic [31:0]       checksum;

   modport master (
      output load_start, load_len, byte_valid, byte_data, fetch_pc,
      input  byte_ready, inst, busy, cpu_run, words_loaded, checksum
   );

   modport slave (
      input  load_start, load_len, byte_valid, byte_data, fetch_pc,
      output byte_ready, inst, busy, cpu_run, words_loaded, checksum
   );
endinterface

// File: rtl/inst_loader.sv
// ----------------------------------------------------------------------------
// inst_loader
//   Owns the 2^ADDR_W x 32-bit instruction RAM. At boot it fills the RAM from
//   a byte stream, assembling big-endian words, then releases the CPU via
//   cpu_run. The fetch unit reads the RAM combinationally through inst.
//
// Ports
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset (RAM contents are kept)
//   bus  : inst_loader_if.slave
//          load_start/load_len     start a session of load_len words
//          byte_valid/byte_data    stream bytes, accepted with byte_ready
//          fetch_pc -> inst        combinational read, 0 while busy
//          busy, cpu_run           session in progress / load complete
//          words_loaded, checksum  count and XOR of words written this session
// ----------------------------------------------------------------------------
module inst_loader #(
   parameter int ADDR_W = 16
) (
   input  logic           clk,
   input  logic           rst,
   inst_loader_if.slave   bus
);
   localparam int            DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t           state, next_state;
   logic             byte_ready_q;
   logic [1:0]       byte_cnt;
   logic [23:0]      word_q;        // first three bytes of the word in flight
   logic [ADDR_W:0]  len_q;
   logic [ADDR_W:0]  words_q;
   logic [31:0]      csum_q;
   logic [31:0]      ram [0:DEPTH-1];

   logic             accept;
   logic             word_done;
   logic [31:0]      full_word;
   logic [ADDR_W:0]  words_inc;
   logic [ADDR_W:0]  len_sat;
   logic             start_ok;

   assign accept    = bus.byte_valid & byte_ready_q;
   assign word_done = accept && (byte_cnt == 2'd3);
   assign full_word = {word_q, bus.byte_data};
   assign words_inc = words_q + ONE;
   assign len_sat   = (bus.load_len > MAX_LEN) ? MAX_LEN : bus.load_len;
   // load_start is only honoured outside a session
   assign start_ok  = bus.load_start && (state != LOAD);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: begin
            if (bus.load_start)
               next_state = (bus.load_len == '0) ? DONE : LOAD;
         end
         LOAD: begin
            if (word_done && (words_inc == len_q))
               next_state = DONE;
         end
         default: next_state = IDLE;
      endcase
   end

   // byte_ready is registered: it follows the state being entered, so it
   // drops on the same edge that writes the final word.
   always_ff @(posedge clk) begin
      if (rst) byte_ready_q <= 1'b0;
      else     byte_ready_q <= (next_state == LOAD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt <= '0;
         word_q   <= '0;
         len_q    <= '0;
         words_q  <= '0;
         csum_q   <= '0;
      end else if (start_ok) begin
         byte_cnt <= '0;
         word_q   <= '0;
         len_q    <= len_sat;
         words_q  <= '0;
         csum_q   <= '0;
      end else if (accept) begin
         byte_cnt <= byte_cnt + 2'd1;
         word_q   <= {word_q[15:0], bus.byte_data};
         if (byte_cnt == 2'd3) begin
            words_q <= words_inc;
            csum_q  <= csum_q ^ full_word;
         end
      end
   end

   // RAM has no reset; a write can only happen on an accepted fourth byte.
   always_ff @(posedge clk) begin
      if (!rst && word_done)
         ram[words_q[ADDR_W-1:0]] <= full_word;
   end

   assign bus.inst         = (state == LOAD) ? 32'h0000_0000
                                             : ram[bus.fetch_pc[ADDR_W+1:2]];
   assign bus.byte_ready   = byte_ready_q;
   assign bus.busy         = (state == LOAD);
   assign bus.cpu_run      = (state == DONE);
   assign bus.words_loaded = words_q;
   assign bus.checksum     = csum_q;
endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;
   localparam int AW    = 6;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   inst_loader_if #(.ADDR_W(AW)) bif();
   inst_loader #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bif));

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: session flags, byte queue, word array.
   bit          m_loading, m_done;
   int          m_len, m_wl;
   logic [31:0] m_csum;
   logic [7:0]  m_part[$];
   logic [31:0] m_ram[DEPTH];
   bit          m_wr[DEPTH];
   logic [7:0]  q_bytes[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model, clock, compare outputs.
   task automatic cyc(input bit r, input bit ls, input int ll, input bit v,
                      input logic [7:0] d, input logic [31:0] pc);
      int idx;
      logic [31:0] w;
      rst = r; bif.load_start = ls; bif.load_len = ll[AW:0];
      bif.byte_valid = v; bif.byte_data = d; bif.fetch_pc = pc;
      if (r) begin
         m_loading = 0; m_done = 0; m_wl = 0; m_csum = 0; m_part.delete();
      end else if (!m_loading && ls) begin
         m_len = (ll > DEPTH) ? DEPTH : ll;
         m_wl = 0; m_csum = 0; m_part.delete();
         m_loading = (m_len != 0);
         m_done    = (m_len == 0);
      end else if (m_loading && v) begin
         m_part.push_back(d);
         if (m_part.size() == 4) begin
            w = {m_part[0], m_part[1], m_part[2], m_part[3]};
            m_ram[m_wl % DEPTH] = w;
            m_wr[m_wl % DEPTH]  = 1;
            m_wl++;
            m_csum ^= w;
            m_part.delete();
            if (m_wl == m_len) begin m_loading = 0; m_done = 1; end
         end
      end
      @(posedge clk); #1;
      chk("byte_ready", {31'b0, bif.byte_ready}, {31'b0, m_loading});
      chk("busy", {31'b0, bif.busy}, {31'b0, m_loading});
      chk("cpu_run", {31'b0, bif.cpu_run}, {31'b0, m_done});
      chk("words_loaded", 32'(bif.words_loaded), m_wl);
      chk("checksum", bif.checksum, m_csum);
      idx = int'((pc >> 2) % DEPTH);
      if (m_loading) chk("inst_busy", bif.inst, 32'h0);
      else if (m_wr[idx]) chk("inst", bif.inst, m_ram[idx]);
   endtask

   task automatic idle(input logic [31:0] pc);
      cyc(0, 0, 0, 0, 8'h00, pc);
   endtask

   // Starts a session of len words fed from q_bytes (random bytes once it
   // runs dry). mode 0: continuous valid, 1: valid toggling 0/1, 2: random.
   // restart_at pulses load_start (len 1) at that stream cycle.
   task automatic run_load(input int len, input int mode, input int restart_at, output int ncyc);
      int k = 0;
      bit v, ls, acc;
      logic [7:0] d;
      ncyc = 0;
      cyc(0, 1, len, 0, 8'h00, $urandom());
      while (m_loading && ncyc < 4000) begin
         case (mode)
            0:       v = 1;
            1:       v = (ncyc % 2 == 1);
            default: v = ($urandom_range(0, 3) != 0);
         endcase
         ls  = (ncyc == restart_at);
         d   = (k < q_bytes.size()) ? q_bytes[k] : 8'($urandom());
         acc = v && m_loading;
         cyc(0, ls, 1, v, d, $urandom());
         if (acc) k++;
         ncyc++;
      end
      chk("load_finished", {31'b0, bif.cpu_run}, 32'd1);
   endtask

   initial begin
      int n;
      rst = 1; bif.load_start = 0; bif.load_len = '0;
      bif.byte_valid = 0; bif.byte_data = '0; bif.fetch_pc = '0;
      m_loading = 0; m_done = 0; m_wl = 0; m_csum = 0; m_len = 0;
      for (int i = 0; i < DEPTH; i++) begin m_wr[i] = 0; m_ram[i] = 0; end

      // Reset state
      cyc(1, 0, 0, 0, 8'h00, 0);
      cyc(1, 1, 2, 1, 8'hFF, 0);
      chk("rst_cpu_run", {31'b0, bif.cpu_run}, 32'd0);
      chk("rst_ready", {31'b0, bif.byte_ready}, 32'd0);

      // Two-word load, continuous valid
      q_bytes = {8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h08};
      run_load(2, 0, -1, n);
      chk("cont_cycles", n, 32'd8);
      chk("cont_words", 32'(bif.words_loaded), 32'd2);
      chk("cont_csum", bif.checksum, 32'h8C01000C);
      idle(32'd0); chk("ram0", bif.inst, 32'h8C010004);
      idle(32'd4); chk("ram1_pc4", bif.inst, 32'h00000008);
      idle(32'd7); chk("ram1_pc7", bif.inst, 32'h00000008);
      chk("done_ready", {31'b0, bif.byte_ready}, 32'd0);

      // Same load, valid toggling
      run_load(2, 1, -1, n);
      chk("toggle_cycles", n, 32'd16);
      chk("toggle_csum", bif.checksum, 32'h8C01000C);
      idle(32'd0); chk("toggle_ram0", bif.inst, 32'h8C010004);

      // Reset after two bytes of a one-word session
      cyc(0, 1, 1, 0, 8'h00, 0);
      cyc(0, 0, 0, 1, 8'hAA, 0);
      cyc(0, 0, 0, 1, 8'hBB, 0);
      cyc(1, 0, 0, 1, 8'hCC, 0);
      chk("midrst_cpu_run", {31'b0, bif.cpu_run}, 32'd0);
      chk("midrst_busy", {31'b0, bif.busy}, 32'd0);
      q_bytes = {8'h12, 8'h34, 8'h56, 8'h78};
      run_load(1, 0, -1, n);
      idle(32'd0); chk("midrst_ram0", bif.inst, 32'h12345678);

      // Reload from DONE: counters cleared, untouched words kept
      q_bytes = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_load(1, 0, -1, n);
      chk("reload_csum", bif.checksum, 32'hDEADBEEF);
      idle(32'd4); chk("reload_ram1", bif.inst, 32'h00000008);
      idle(32'd0); chk("reload_ram0", bif.inst, 32'hDEADBEEF);

      // Zero-length session
      run_load(0, 0, -1, n);
      chk("zero_cycles", n, 32'd0);
      chk("zero_words", 32'(bif.words_loaded), 32'd0);

      // load_start during LOAD is ignored
      q_bytes.delete();
      run_load(3, 0, 4, n);
      chk("restart_words", 32'(bif.words_loaded), 32'd3);
      chk("restart_cycles", n, 32'd12);

      // Oversized length saturates to the RAM depth; addresses wrap
      run_load(100, 2, -1, n);
      chk("sat_words", 32'(bif.words_loaded), DEPTH);
      for (int i = 0; i < 40; i++) idle($urandom());

      // Random sessions, occasionally abandoned by reset
      for (int s = 0; s < 6; s++) begin
         int len;
         len = $urandom_range(0, 20);
         if (s == 3) begin
            cyc(0, 1, len + 1, 0, 8'h00, $urandom());
            for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 8'($urandom()), $urandom());
            cyc(1, 0, 0, 0, 8'h00, $urandom());
         end
         run_load(len, $urandom_range(0, 2), -1, n);
         for (int i = 0; i < 10; i++) idle($urandom());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
